// File: rtl/core_ex_mdu_pkg.sv
// Shared M-op encodings, FSM state type and operand-signedness helpers for the EX-stage MDU.
// Pure declarations: no logic, no latency, no flow control.
// Build option CORE_MDU_FAST_MUL_EN is left undefined by default.
package core_ex_mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/core_ex_mdu_iter.sv
// One shift-add (multiply) or restoring shift-subtract (divide) step on unsigned magnitudes.
// Purely combinational: zero latency, no flow control.
// Multiply: {part,lo} is the 2*XLEN accumulator. Divide: part = remainder, lo = dividend/quotient.
module core_ex_mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] part_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] part_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, part_in} + (lo_in[0] ? {1'b0, b_in} : '0);
    shifted  = {part_in, lo_in[XLEN-1]};
    diff     = shifted - {1'b0, b_in};
    part_out = sum[XLEN:1];
    lo_out   = {sum[0], lo_in[XLEN-1:1]};
    if (is_div) begin
      // Borrow out of the top bit means the divisor did not fit: restore.
      if (diff[XLEN]) begin
        part_out = shifted[XLEN-1:0];
        lo_out   = {lo_in[XLEN-2:0], 1'b0};
      end else begin
        part_out = diff[XLEN-1:0];
        lo_out   = {lo_in[XLEN-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/core_ex_mdu.sv
// Iterative RV M-extension multiply/divide unit (MUL..REMU) beside the EX ALU.
// Latency: XLEN+1 cycles from accept to out_valid; 1 cycle for div-by-zero/overflow, and for multiplies under CORE_MDU_FAST_MUL_EN.
// Backpressure: in_ready only in IDLE; result held until out_ready; flush cancels from any state.
module core_ex_mdu
  import core_ex_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  mdu_state_e       state_q, state_d;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  b_q, lo_q, part_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  result_q;

  logic             load, step, res_wr;
  logic [XLEN-1:0]  res_d;
  logic [XLEN-1:0]  part_nx, lo_nx;

  // Accept-side operand conditioning
  logic             s1_neg, s2_neg, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0]  mag1, mag2, special_res;

  always_comb begin
    s1_neg   = rs1_signed(op) & rs1[XLEN-1];
    s2_neg   = rs2_signed(op) & rs2[XLEN-1];
    mag1     = s1_neg ? -rs1 : rs1;
    mag2     = s2_neg ? -rs2 : rs2;
    neg_in   = (op == OP_REM) ? s1_neg : (s1_neg ^ s2_neg);
    div_zero = op[2] && (rs2 == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special_res = '1;
    if (div_zero)     special_res = op[1] ? rs1 : '1;
    else if (div_ovf) special_res = op[1] ? '0 : rs1;
  end

`ifdef CORE_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  logic [XLEN-1:0]   fast_res;
  always_comb begin
    fast_a    = {{XLEN{rs1_signed(op) & rs1[XLEN-1]}}, rs1};
    fast_b    = {{XLEN{rs2_signed(op) & rs2[XLEN-1]}}, rs2};
    fast_prod = fast_a * fast_b;
    fast_res  = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  core_ex_mdu_iter #(.XLEN(XLEN)) u_iter (
    .is_div   (op_q[2]),
    .part_in  (part_q),
    .lo_in    (lo_q),
    .b_in     (b_q),
    .part_out (part_nx),
    .lo_out   (lo_nx)
  );

  // Sign fix-up applied to the final iteration's outputs on entry to DONE
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   div_raw, calc_res;

  always_comb begin
    prod     = {part_nx, lo_nx};
    prod_fix = neg_q ? -prod : prod;
    div_raw  = op_q[1] ? part_nx : lo_nx;
    if (op_q[2])               calc_res = neg_q ? -div_raw : div_raw;
    else if (op_q == OP_MUL)   calc_res = prod_fix[XLEN-1:0];
    else                       calc_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    res_wr  = 1'b0;
    res_d   = result_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (div_zero || div_ovf) begin
              state_d = ST_DONE;
              res_wr  = 1'b1;
              res_d   = special_res;
`ifdef CORE_MDU_FAST_MUL_EN
            end else if (!op[2]) begin
              state_d = ST_DONE;
              res_wr  = 1'b1;
              res_d   = fast_res;
`endif
            end else begin
              state_d = ST_CALC;
              load    = 1'b1;
            end
          end
        end
        ST_CALC: begin
          step = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_DONE;
            res_wr  = 1'b1;
            res_d   = calc_res;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      lo_q     <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q   <= op;
        neg_q  <= neg_in;
        // Multiplier sits in lo so its LSB gates each add; dividend sits in lo to shift out MSB-first.
        b_q    <= op[2] ? mag2 : mag1;
        lo_q   <= op[2] ? mag1 : mag2;
        part_q <= '0;
        cnt_q  <= CNT_W'(XLEN - 1);
      end else if (step) begin
        part_q <= part_nx;
        lo_q   <= lo_nx;
        cnt_q  <= cnt_q - CNT_W'(1);
      end
      if (res_wr) result_q <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_core_ex_mdu.sv
// Directed self-checking bench for core_ex_mdu at XLEN = 32.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
module tb_core_ex_mdu;

  localparam int XLEN = 32;
`ifdef CORE_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  core_ex_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Issues one op, returns the cycle (handshake = 0) out_valid first rose and the result; lat = -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output logic [XLEN-1:0] res, output int lat);
    int cyc;
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = out_valid ? cyc : -1;
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [2:0]      ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [XLEN-1:0] exp [4] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [XLEN-1:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
      n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL mul_result op=%0d got %h want %h", ops[i], r, exp[i]); end
      n_checks++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL mul_latency op=%0d got %0d want %0d", ops[i], lat, MUL_LAT); end
    end
  endtask

  task automatic test_div;
    logic [2:0]      ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [XLEN-1:0] a   [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [XLEN-1:0] b   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [XLEN-1:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    logic [XLEN-1:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], a[i], b[i], r, lat);
      n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL div_result op=%0d got %h want %h", ops[i], r, exp[i]); end
      n_checks++; if (lat != DIV_LAT) begin n_fail++; $display("FAIL div_latency op=%0d got %0d want %0d", ops[i], lat, DIV_LAT); end
    end
  endtask

  task automatic test_special;
    logic [2:0]      ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [XLEN-1:0] a   [4] = '{32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [XLEN-1:0] b   [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [XLEN-1:0] exp [4] = '{32'hFFFFFFFF, 32'd100, 32'h80000000, 32'd0};
    logic [XLEN-1:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], a[i], b[i], r, lat);
      n_checks++; if (r !== exp[i]) begin n_fail++; $display("FAIL special_result idx=%0d got %h want %h", i, r, exp[i]); end
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL special_latency idx=%0d got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %0b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL bp_result cyc=%0d got %h want %h", i, result, 32'd14); end
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d in_ready=%0b busy=%0b out_valid=%0b want 0/1/1", i, in_ready, busy, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush;
    logic [XLEN-1:0] r;
    int lat;
    logic seen;
    // flush beats in_valid while idle
    op = 3'd0; rs1 = 32'd2; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy got %0b want 0", busy); end
    // flush at cycle 10 of a DIV
    op = 3'd4; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_calc in_ready=%0b busy=%0b want 1/0", in_ready, busy);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_out_valid got %0b want 0", seen); end
    run_op(3'd0, 32'd3, 32'd5, r, lat);
    n_checks++; if (r !== 32'd15) begin n_fail++; $display("FAIL flush_then_mul got %h want %h", r, 32'd15); end
  endtask

  task automatic test_async_reset;
    logic seen;
    op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got %0b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL arst_immediate out_valid=%0b busy=%0b in_ready=%0b want 0/0/1", out_valid, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL arst_no_stale got %0b want 0", seen); end
  endtask

  initial begin
    #3;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ex_mdu.md
# core_ex_mdu

Parametrised multiply/divide unit for the EX stage, implementing RV M-extension semantics (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a configurable XLEN. It sits beside the single-cycle EX ALU. Operands arrive over a valid/ready handshake, are computed iteratively over multiple cycles, and the result is returned over a second valid/ready handshake. The pipeline stalls on in_ready/out_valid and can cancel an operation in flight with flush.

## Interface
- XLEN, 32, operand/result width; even, ≥ 8
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports (clock and reset first):
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous cancel of any in-flight or pending operation
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  M-op select, encodings from `core_defines.v`
- rs1  in  XLEN  operand 1 (dividend / multiplicand)
- rs2  in  XLEN  operand 2 (divisor / multiplier)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result, stable while out_valid && !out_ready
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: when in_valid && !flush, latch op/rs1/rs2 and go to CALC. Special cases go straight to DONE with the final result: divide by zero, and signed overflow.
- CALC: one iteration per cycle for XLEN cycles; the counter counts down from XLEN−1 and the last iteration goes to DONE.
- DONE: out_valid = 1. On out_ready, go to IDLE.
- Signed handling: operands are converted to magnitudes on accept, with a result-sign flag recorded.
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV: quotient sign = sign(rs1) ^ sign(rs2).
  - REM: remainder sign = sign(rs1).
  - The sign is applied when entering DONE.
- Multiply: shift-add into a 2·XLEN accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the signed-corrected product.
- Divide: restoring shift-subtract. One quotient bit per cycle, remainder held in an XLEN+1 partial register.
- Divide by zero (rs2 = 0):
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: result = rs1.
- Signed overflow (DIV/REM, rs1 = 1<<(XLEN−1), rs2 = all ones):
  - DIV: quotient = rs1.
  - REM: remainder = 0.
- flush: the next state is IDLE from any state. out_valid drops the next cycle and the result is discarded. flush has priority over in_valid and out_ready in the same cycle. When flush and in_valid are both high in IDLE, the input is not accepted.

## Timing
- Reset values:
  - state IDLE, out_valid 0, result 0, busy 0, in_ready 1.
  - All internal operand, accumulator and counter registers 0.
- Reset mid-operation: asynchronous return to IDLE. Nothing is output.
- Handshake cycle = cycle 0:
  - Normal op: out_valid is first high in cycle XLEN+1 (33 for XLEN = 32).
  - Special-case divide: out_valid is first high in cycle 1.
- in_ready is combinational from state only. It has no path from in_valid or out_ready.
- Throughput: the next accept is possible in the cycle after the result handshake. There is no overlap.
- The result register is written only on entry to DONE.

## Configuration
- CORE_MDU_FAST_MUL_EN
  - Defined: all multiply ops use a single-cycle XLEN×XLEN multiplier, going IDLE→DONE with out_valid in cycle 1. Divide is unchanged.
  - Undefined: multiply is iterative (XLEN cycles). No `*` operator is synthesised.

## Structure
- `core_defines.v` gains:
  - the M-op encodings: MUL 0, MULH 1, MULHSU 2, MULHU 3, DIV 4, DIVU 5, REM 6, REMU 7
  - the FSM state encodings
  - the CORE_MDU_FAST_MUL_EN default (undefined)
- One sub-module, core_ex_mdu_iter: the per-cycle shift-add / shift-subtract datapath step, purely combinational. The FSM, counter, sign fix-up and handshake stay in core_ex_mdu.

## Test plan
All scenarios use XLEN = 32.
- MUL/MULH/MULHU/MULHSU with rs1 = rs2 = 0xFFFFFFFF → 0x00000001 / 0x00000000 / 0xFFFFFFFE / 0xFFFFFFFF. out_valid at cycle 33, or at cycle 1 with CORE_MDU_FAST_MUL_EN.
- DIV/REM with rs1 = 0xFFFFFFF9 (−7), rs2 = 2 → 0xFFFFFFFD / 0xFFFFFFFF. DIVU with 100 / 7 → 14; REMU → 2.
- DIVU 100 / 0 → 0xFFFFFFFF; REM 100 / 0 → 100. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. All four have out_valid in cycle 1.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid → result stable, in_ready 0, busy 1. Then out_ready = 1 → in_ready 1 the next cycle.
- flush in cycle 10 of a DIV, with in_valid also high → IDLE the next cycle, no out_valid ever, in_ready 1. A new MUL 3 × 5 then returns 15.
- rst_n pulsed low mid-CALC (asynchronous, between edges) → out_valid/busy 0 and in_ready 1 immediately. No stale result after release.
